// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the sequential ALU and its multiplier.
//   - OP_*    : 3-bit opcode map (ADD/SUB/AND/OR/XOR as on the old combinational
//               ALU, plus MUL and NOP)
//   - state_e : control FSM encoding of alu_seq
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;  // 3'b111 decodes as NOP as well

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one partial product per
// step, WIDTH steps per product.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and clear accumulator and step counter
//   step       : perform one shift-add step
//   a, b       : operands (sampled on start)
//   done       : the current step is the last one; prod is then the full product
//   prod       : accumulator including the current step's partial product
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // prod is look-ahead so the caller can register the result on the same
    // edge as the final step, giving WIDTH cycles in the MUL state.
    assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with flags and optional multi-cycle MUL.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, sel)
//   out_valid/out_ready : result handshake (out, out_hi, carry, ovf, zero)
//   out_hi              : high half of MUL product, 0 otherwise
//   carry               : ADD carry-out / SUB borrow (a < b unsigned)
//   ovf                 : signed overflow for ADD/SUB
//   zero                : out == 0 and out_hi == 0
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid holds its payload stable until then. One operation in flight.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_step;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_out;
    logic               res_carry;
    logic               res_ovf;

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    // With MUL disabled opcode 101 falls through to the NOP decode below.
    assign is_mul    = (MUL_EN != 0) && (sel == OP_MUL);

    assign out    = out_q;
    assign out_hi = out_hi_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .start (mul_start),
                .step  (mul_step),
                .a     (a),
                .b     (b),
                .done  (mul_done),
                .prod  (mul_prod)
            );
        end else begin : g_no_mul
            logic unused_mul;
            assign unused_mul = mul_start ^ mul_step;
            assign mul_done   = 1'b0;
            assign mul_prod   = '0;
        end
    endgenerate

    // Single-cycle result. The extra top bit of diff is the unsigned borrow.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        res_out   = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (sel)
            OP_ADD: begin
                res_out   = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_out   = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_out = a & b;
            OP_OR:   res_out = a | b;
            OP_XOR:  res_out = a ^ b;
            default: res_out = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_hi_d  = out_hi_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if ((state_q == HOLD) && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (is_mul) begin
                        state_d   = MUL;
                        mul_start = 1'b1;
                    end else begin
                        state_d  = HOLD;
                        out_d    = res_out;
                        out_hi_d = '0;
                        carry_d  = res_carry;
                        ovf_d    = res_ovf;
                        zero_d   = (res_out == '0);
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    state_d  = HOLD;
                    out_d    = mul_prod[WIDTH-1:0];
                    out_hi_d = mul_prod[2*WIDTH-1:WIDTH];
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = (mul_prod == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            out_hi_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=4, MUL_EN=1).
module tb_alu_seq;

    localparam int W  = 4;
    localparam int RW = 2 * W + 3;  // {out_hi, out, carry, ovf, zero}

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         carry;
    logic         ovf;
    logic         zero;

    logic [RW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            ready_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        int ux, uy, sx, sy, r, hi, lo, c, o;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 8) ? ux - 16 : ux;
        sy = (uy >= 8) ? uy - 16 : uy;
        hi = 0; c = 0; o = 0;
        case (op)
            3'd0: begin r = ux + uy; lo = r % 16; c = (r > 15) ? 1 : 0;
                        o = ((sx + sy) > 7 || (sx + sy) < -8) ? 1 : 0; end
            3'd1: begin lo = (ux - uy + 16) % 16; c = (ux < uy) ? 1 : 0;
                        o = ((sx - sy) > 7 || (sx - sy) < -8) ? 1 : 0; end
            3'd2: lo = int'(x & y);
            3'd3: lo = int'(x | y);
            3'd4: lo = int'(x ^ y);
            3'd5: begin r = ux * uy; lo = r % 16; hi = r / 16; end
            default: lo = 0;
        endcase
        return {W'(hi), W'(lo), c[0], o[0], (lo == 0 && hi == 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ready_mode(input int m);
        ready_mode = m;
        if (m == 0) out_ready = 1'b1;
        if (m == 2) out_ready = 1'b0;
    endtask

    // Presents one operation and returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok;
        in_valid = 1'b1;
        sel = op;
        a = x;
        b = y;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(model(op, x, y));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        sel = $urandom_range(0, 7);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- sink ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [RW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stale_result: out_valid=1 out=%0h with no operation pending", out);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({out_hi, out, carry, ovf, zero}), 32'(e));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sel = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({out_hi, out, carry, ovf, zero}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);

        // Single-cycle ops, latency 1
        set_ready_mode(0);
        issue(3'd0, 4'b0011, 4'b0001);
        @(negedge clk);
        check("add_latency_valid", 32'(out_valid), 32'd1);
        check("add_out", 32'(out), 32'b0100);
        idle_cycles(1);
        issue(3'd0, 4'b1111, 4'b0001);
        @(negedge clk);
        check("add_wrap_carry_zero", 32'({carry, zero, ovf}), 32'b110);
        idle_cycles(1);
        issue(3'd0, 4'b0111, 4'b0001);
        issue(3'd1, 4'b0100, 4'b0001);
        issue(3'd1, 4'b0001, 4'b0010);
        @(negedge clk);
        check("sub_borrow", 32'({out, carry}), 32'b11111);
        idle_cycles(1);

        // MUL timing: in_ready low for WIDTH cycles, out_valid WIDTH+1 after accept
        issue(3'd5, 4'b1111, 4'b1111);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            check("mul_in_ready_low", 32'(in_ready), 32'd0);
        end
        check("mul_latency", 32'(lat), 32'd5);
        check("mul_product", 32'({out_hi, out}), 32'b11100001);
        idle_cycles(1);

        // Backpressure: result held, then chained accept with no bubble
        set_ready_mode(2);
        issue(3'd4, 4'b1100, 4'b1010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold", 32'({out_valid, in_ready, out}), 32'b10_0110);
        end
        @(posedge clk);
        #1;
        set_ready_mode(0);
        issue(3'd3, 4'b1100, 4'b1010);
        @(negedge clk);
        check("chain_no_bubble", 32'({out_valid, out}), 32'b1_1110);
        idle_cycles(1);

        // Reset two cycles into a MUL: the product must never appear
        issue(3'd5, 4'b0011, 4'b0101);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_mul_valid", 32'(out_valid), 32'd0);
        check("rst_mid_mul_out", 32'(out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_mul_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_stale_after_rst", 32'(out_valid), 32'd0);
        end
        idle_cycles(1);

        // NOP encodings
        issue(3'd7, 4'b1011, 4'b0110);
        @(negedge clk);
        check("nop_zero", 32'({out, zero}), 32'b0000_1);
        idle_cycles(1);
        issue(3'd6, 4'b1111, 4'b1111);

        // Randomized traffic with random sink backpressure
        set_ready_mode(1);
        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        set_ready_mode(0);
        check("drain", 32'(exp_q.size()), 32'd0);
        idle_cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
